// File: rtl/md5_search_pkg.sv
// md5_search_pkg: shared state encoding and sizing for the MD5 search result path
package md5_search_pkg;
   localparam int CAND_W               = 32;
   localparam int PIPE_LATENCY_DEFAULT = 64;
   localparam int LANES_DEFAULT        = 2;
   typedef enum logic [1:0] {IDLE, ARMED, HOLD, DRAINED} state_t;
endpackage

// File: rtl/base_delay_line.sv
// base_delay_line: fixed-depth shift register aligning issued bases with their found pulses
module base_delay_line #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);
   logic [WIDTH-1:0] r_stage [DEPTH];
   // advance one stage per cycle; a flush empties every entry so nothing stale can qualify
   always_ff @(posedge i_clk) begin
      if (i_flush) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end
   assign o_data = r_stage[DEPTH-1];
endmodule

// File: rtl/result_capture.sv
// result_capture: latches the first matching candidate from the hash lanes and counts issued candidates
module result_capture
   import md5_search_pkg::*;
#(
   parameter int PIPE_LATENCY = PIPE_LATENCY_DEFAULT,
   parameter int LANES        = LANES_DEFAULT
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [CAND_W-1:0] target,
   input  logic              running,
   input  logic [LANES-1:0]  found_lane,
   input  logic              clear,
   output logic [CAND_W-1:0] result,
   output logic              result_valid,
   input  logic              result_ready,
   output logic              extra_match,
   output logic [CAND_W-1:0] tested
);
   localparam logic [CAND_W-1:0] MAX = '1;
   state_t            r_state, w_state_nxt;
   logic [CAND_W-1:0] r_result, r_tested, w_tested_nxt, w_dl_in, w_dl_out;
   logic              r_extra, w_capture, w_extra_set, w_hit, w_unused;
   assign w_dl_in  = {running, target[CAND_W-1:1]};
   assign w_unused = target[0];
   base_delay_line #(.DEPTH(PIPE_LATENCY), .WIDTH(CAND_W)) u_delay (
      .i_clk   (CLK),
      .i_flush (reset | clear),
      .i_data  (w_dl_in),
      .o_data  (w_dl_out)
   );
   assign w_hit        = |found_lane && w_dl_out[CAND_W-1];
   assign w_tested_nxt = !running ? r_tested
                       : (r_tested > MAX - CAND_W'(LANES)) ? MAX : r_tested + CAND_W'(LANES);
   // next state plus capture/extra decisions; clear overrides everything
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_extra_set = 1'b0;
      if (clear) w_state_nxt = IDLE;
      else if (r_state == IDLE && running) w_state_nxt = ARMED;
      else if (r_state == ARMED && w_hit) begin
         w_state_nxt = HOLD;
         w_capture   = 1'b1;
         w_extra_set = &found_lane;
      end else if (r_state == HOLD) begin
         w_extra_set = w_hit;
         if (result_ready) w_state_nxt = DRAINED;
      end
   end
   // state register
   always_ff @(posedge CLK) begin
      r_state <= reset ? IDLE : w_state_nxt;
   end
   // result, sticky extra flag and saturating candidate count; result survives clear
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_result <= '0;
         r_extra  <= 1'b0;
         r_tested <= '0;
      end else begin
         if (w_capture) r_result <= {w_dl_out[CAND_W-2:0], ~found_lane[0]};
         r_extra  <= !clear && (r_extra || w_extra_set);
         r_tested <= clear ? '0 : w_tested_nxt;
      end
   end
   assign result       = r_result;
   assign result_valid = (r_state == HOLD);
   assign extra_match  = r_extra;
   assign tested       = r_tested;
endmodule
